// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared state encoding, grant owners and word width for the ARM SRAM arbiter
package arm_mem_pkg;
   localparam int WORD_W = 32;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;
   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_MEM = 1'b1;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter with zero flag for SRAM wait states
module sram_wait_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = load ? load_val : (dec && !zero) ? cnt_q - W'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign zero = (cnt_q == '0);
endmodule

// File: rtl/arm_sram_arbiter.sv
// arm_sram_arbiter: shares one multi-cycle SRAM between ARM fetch and MEM stages, MEM first
module arm_sram_arbiter
   import arm_mem_pkg::*;
#(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_ready,
   output logic              pipe_freeze,
   output logic              if_stall,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata,
   output logic              sram_en,
   output logic              sram_we_n
);
   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
   logic [WORD_W-1:0]   mem_rdata_q, mem_rdata_d;
   logic                mem_req, grant, cap, zero;
   logic                unused_addr_bits;
   always_comb begin
      mem_req     = mem_rd | mem_wr;
      grant       = (state_q == S_IDLE) && (mem_req || if_req);
      cap         = (state_q == S_ACCESS) && zero;
      state_d     = (state_q == S_IDLE) ? (grant ? S_ACCESS : S_IDLE) :
                    (state_q == S_ACCESS) ? (zero ? S_DONE : S_ACCESS) : S_IDLE;
      owner_d     = grant ? (mem_req ? GRANT_MEM : GRANT_IF) : owner_q;
      wr_d        = grant ? (mem_req && mem_wr) : wr_q;
      addr_d      = grant ? (mem_req ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2]) : addr_q;
      wdata_d     = grant ? mem_wdata : wdata_q;
      if_rdata_d  = (cap && owner_q == GRANT_IF) ? sram_rdata : if_rdata_q;
      mem_rdata_d = (cap && owner_q == GRANT_MEM) ? sram_rdata : mem_rdata_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_q     <= GRANT_IF;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end
   sram_wait_counter #(.W(4)) u_wait (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (grant),
      .dec     (state_q == S_ACCESS),
      .load_val(4'(WAIT_CYCLES - 1)),
      .zero    (zero)
   );
   assign sram_en     = (state_q == S_ACCESS);
   assign sram_we_n   = !(sram_en && wr_q);
   assign sram_addr   = addr_q;
   assign sram_wdata  = wdata_q;
   assign if_ready    = (state_q == S_DONE) && (owner_q == GRANT_IF);
   assign mem_ready   = (state_q == S_DONE) && (owner_q == GRANT_MEM);
   assign if_rdata    = if_rdata_q;
   assign mem_rdata   = mem_rdata_q;
   assign pipe_freeze = mem_req & ~mem_ready;
   assign if_stall    = if_req & ~if_ready;
   assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2], mem_addr[1:0]};
endmodule

// File: tb/tb_arm_sram_arbiter.sv
// tb_arm_sram_arbiter: vector table plus scoreboard checks of the SRAM arbiter with a behavioural SRAM
module tb_arm_sram_arbiter;
   localparam int W0 = 3;
   typedef struct {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [17:0] exp_sa;
   } vec_t;
   typedef struct {
      logic        own;
      logic [31:0] rdata;
      logic        chk;
      int          cyc;
   } sb_t;
   logic clk = 1'b0;
   logic rst_n, if_req, mem_rd, mem_wr;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
   logic if_ready, mem_ready, pipe_freeze, if_stall, sram_en, sram_we_n;
   logic [17:0] sram_addr;
   logic [31:0] if_rdata1, mem_rdata1, sram_wdata1, sram_rdata1;
   logic if_ready1, mem_ready1, pipe_freeze1, if_stall1, sram_en1, sram_we_n1;
   logic [17:0] sram_addr1;
   logic [31:0] mem [0:1023];
   logic        bk_we;
   logic [9:0]  bk_a;
   logic [31:0] bk_d;
   int checks = 0, failures = 0, cyc = 0;
   logic mon_on = 1'b1;
   sb_t q[$];
   sb_t e;
   vec_t vt [8];
   vec_t v;
   int t0, d;
   logic rdy, got;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (bk_we) mem[bk_a] <= bk_d;
      else if (sram_en && !sram_we_n) mem[sram_addr[9:0]] <= sram_wdata;
   end
   assign sram_rdata  = mem[sram_addr[9:0]];
   assign sram_rdata1 = mem[sram_addr1[9:0]];
   arm_sram_arbiter #(.ADDR_W(18), .WAIT_CYCLES(W0)) u0 (
      .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ready(if_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .pipe_freeze(pipe_freeze), .if_stall(if_stall), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_en(sram_en), .sram_we_n(sram_we_n)
   );
   arm_sram_arbiter #(.ADDR_W(18), .WAIT_CYCLES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1),
      .if_ready(if_ready1), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
      .pipe_freeze(pipe_freeze1), .if_stall(if_stall1), .sram_addr(sram_addr1),
      .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1), .sram_en(sram_en1), .sram_we_n(sram_we_n1)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
      end
   endtask
   task automatic bk_write(input logic [9:0] a, input logic [31:0] dd);
      @(posedge clk); #1;
      bk_we = 1'b1; bk_a = a; bk_d = dd;
      @(posedge clk); #1;
      bk_we = 1'b0;
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_if_ready"}, if_ready, 0);
      chk({tag, "_mem_ready"}, mem_ready, 0);
      chk({tag, "_sram_en"}, sram_en, 0);
      chk({tag, "_sram_we_n"}, sram_we_n, 1);
      chk({tag, "_sram_addr"}, sram_addr, 0);
      chk({tag, "_sram_wdata"}, sram_wdata, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_mem_rdata"}, mem_rdata, 0);
   endtask
   always @(negedge clk) begin
      if (mon_on && (if_ready || mem_ready)) begin
         chk("both_ready", if_ready & mem_ready, 0);
         if (q.size() == 0) chk("unexpected_ready", {if_ready, mem_ready}, 0);
         else begin
            e = q.pop_front();
            chk("ready_owner", mem_ready, e.own);
            chk("ready_cycle", cyc, e.cyc);
            if (e.chk) chk(e.own ? "mem_rdata" : "if_rdata", e.own ? mem_rdata : if_rdata, e.rdata);
         end
      end
   end
   initial begin
      vt[0] = '{0, 32'h10,  32'h0,        32'hE3A00005, 18'd4};
      vt[1] = '{2, 32'h400, 32'hDEADBEEF, 32'h0,        18'd256};
      vt[2] = '{2, 32'h800, 32'h12345678, 32'h0,        18'd512};
      vt[3] = '{1, 32'h800, 32'h0,        32'h12345678, 18'd512};
      vt[4] = '{1, 32'h400, 32'h0,        32'hDEADBEEF, 18'd256};
      vt[5] = '{0, 32'h13,  32'h0,        32'hE3A00005, 18'd4};
      vt[6] = '{3, 32'h20,  32'hA5A5A5A5, 32'h0,        18'd8};
      vt[7] = '{1, 32'h22,  32'h0,        32'hA5A5A5A5, 18'd8};
      rst_n = 1'b0; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      if_addr = '0; mem_addr = '0; mem_wdata = '0; bk_we = 1'b0; bk_a = '0; bk_d = '0;
      bk_write(10'd0, 32'h11111111);
      bk_write(10'd1, 32'h22222222);
      bk_write(10'd4, 32'hE3A00005);
      @(negedge clk);
      chk_reset_vals("rst0");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         v = vt[i];
         @(posedge clk); #1;
         if_req = (v.kind == 0); mem_rd = (v.kind == 1 || v.kind == 3); mem_wr = (v.kind >= 2);
         if_addr = v.addr; mem_addr = v.addr; mem_wdata = v.wdata;
         t0 = cyc;
         q.push_back('{v.kind != 0, v.exp_rdata, v.kind < 2, t0 + W0 + 1});
         got = 1'b0;
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            rdy = if_ready || mem_ready;
            d = cyc - t0;
            if (d >= 1 && d <= W0) begin
               chk("sram_en", sram_en, 1);
               chk("sram_addr", sram_addr, v.exp_sa);
               chk("sram_we_n", sram_we_n, v.kind < 2);
               if (v.kind >= 2) chk("sram_wdata", sram_wdata, v.wdata);
            end else chk("sram_en_off", sram_en, 0);
            chk(v.kind == 0 ? "if_stall" : "pipe_freeze", v.kind == 0 ? if_stall : pipe_freeze, !rdy);
            got = rdy;
         end
         if (!got) chk("timeout", 0, 1);
         @(posedge clk); #1;
         if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      end
      @(posedge clk); #1;
      mem_wr = 1'b1; mem_addr = 32'h404; mem_wdata = 32'h55AA55AA;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0; mem_wr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst_mid");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("post_rst_ready", {if_ready, mem_ready}, 0);
         chk("post_rst_en", sram_en, 0);
      end
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h10; mem_rd = 1'b1; mem_addr = 32'h800;
      t0 = cyc;
      q.push_back('{1'b1, 32'h12345678, 1'b1, t0 + W0 + 1});
      q.push_back('{1'b0, 32'hE3A00005, 1'b1, t0 + 2 * (W0 + 2) - 1});
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clk);
         chk("en_ready_overlap", sram_en & (if_ready | mem_ready), 0);
         got = if_ready;
         if (mem_ready) begin
            @(posedge clk); #1;
            mem_rd = 1'b0;
         end
      end
      if (!got) chk("contention_timeout", 0, 1);
      @(posedge clk); #1;
      if_req = 1'b0; mem_rd = 1'b0;
      repeat (2) @(posedge clk);
      chk("sb_empty", q.size(), 0);
      mon_on = 1'b0;
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h0;
      @(negedge clk);
      chk("w1_c0_ready", if_ready1, 0);
      chk("w1_c0_en", sram_en1, 0);
      @(negedge clk);
      chk("w1_c1_en", sram_en1, 1);
      chk("w1_c1_addr", sram_addr1, 0);
      chk("w1_c1_ready", if_ready1, 0);
      @(negedge clk);
      chk("w1_c2_ready", if_ready1, 1);
      chk("w1_c2_rdata", if_rdata1, 32'h11111111);
      chk("w1_c2_en", sram_en1, 0);
      @(posedge clk); #1;
      if_addr = 32'h4;
      @(negedge clk);
      chk("w1_c3_ready", if_ready1, 0);
      chk("w1_c3_en", sram_en1, 0);
      @(negedge clk);
      chk("w1_c4_en", sram_en1, 1);
      chk("w1_c4_addr", sram_addr1, 1);
      @(negedge clk);
      chk("w1_c5_ready", if_ready1, 1);
      chk("w1_c5_rdata", if_rdata1, 32'h22222222);
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      chk("w1_c6_ready", if_ready1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
